fv_core_dup_sequencer: RTL
==========================

// Module: fv_core_dup_sequencer
// PURPOSE
//  Sequences one duplicate-execution (DUP) check set in the FV core execute stage:
//  counts committed original instrs up to the DUP sync marker, then counts the same number of duplicates.
//  Waits out the commit-to-RF-write latency, then pulses dup_sync_ready so RF compare logic may sample.
//  Sits beside the EX queue and RF tracker; drives their DUP sync/done controls.
// PARAMETERS
//  MAX_COMMIT   2   commit lanes per cycle, lane 1 oldest
//  CNT_W        10  width of instr counters
//  RF_WR_DELAY  2   cycles from last duplicate commit to its RF write (1..15)
//  MAX_SEQ_LEN  64  max original instrs per set (< 2**CNT_W)
// PORTS
//  clk                 in   1           clock, all state on posedge
//  reset               in   1           async, active-high reset
//  dup_enable          in   1           DUP checking enabled
//  cf_enable           in   1           control-flow tracking enabled; required with dup_enable
//  one_set             in   1           1: stop after first set; 0: run sets back to back
//  abort               in   1           discard set in progress (harness kill of uncommitted instrs)
//  commit              in   MAX_COMMIT  per-lane commit strobe
//  commit_is_sync      in   MAX_COMMIT  per-lane: committing instr is the DUP sync marker
//  dup_phase           out  3           state encoding, see BEHAVIOUR
//  orig_count          out  CNT_W       originals committed in current set
//  dup_count           out  CNT_W       duplicates committed in current set
//  dup_sync_ready      out  1           1-cycle pulse: set complete, RF values comparable
//  dup_done            out  1           sticky: set finished in one_set mode
//  seq_error           out  1           sticky: sequencing violation
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE(0). seq_error/dup_done clear only on reset.
//  States: IDLE=0 ORIG=1 DUP=2 WAIT_RF=3 SYNC=4 DONE=5 ERR=6.
//  go = dup_enable & cf_enable. !go in ORIG/DUP/WAIT_RF/SYNC -> IDLE next cycle, counters to 0.
//  IDLE: go -> ORIG (commits in that cycle are ignored).
//  ORIG: k = lowest lane with commit&commit_is_sync.
//   No k: orig_count += popcount(commit).
//   k exists: orig_count += commits in lanes <k; marker itself not counted; lanes >k add to dup_count; -> DUP.
//   commit_is_sync without commit is ignored. A second marker in lanes >k -> ERR.
//  DUP: dup_count += popcount(commit); any commit&commit_is_sync -> ERR.
//   new dup_count == orig_count -> WAIT_RF; > orig_count -> ERR.
//   Marker with orig_count==0 and no trailing commits -> WAIT_RF directly (empty set legal).
//  WAIT_RF: timer loaded RF_WR_DELAY-1 on entry; decrements; at 0 -> SYNC. Commits ignored.
//   Total latency: last duplicate commit edge + RF_WR_DELAY cycles = dup_sync_ready high.
//  SYNC: dup_sync_ready=1 this cycle only (registered, decoded from state).
//   one_set=1 -> DONE, dup_done<=1; else -> ORIG with counters cleared.
//  DONE: absorbing until reset; commits ignored; dup_phase=5.
//  ERR: seq_error<=1 on entry; absorbing until reset.
//  Overflow: orig_count increment reaching > MAX_SEQ_LEN -> ERR (counter holds old value).
//  abort: in ORIG/DUP -> ORIG, counters cleared, same-cycle commits discarded.
//   Ignored in IDLE/WAIT_RF/SYNC/DONE/ERR (those instrs already committed).
//  Priority per cycle: reset > !go > abort > ERR detection > normal transition.
//  Counters are outputs of registers; no combinational path from inputs to outputs.
// TESTING
//  Basic: go, 3 single commits, marker in lane1, 3 commits -> dup_count=3 ORIG=3, sync pulse 2 cycles later.
//  Lane split: ORIG, commit=2'b11 with sync on lane2 -> orig_count+1, DUP; commit 2'b11 with orig=2 -> match, WAIT_RF.
//  Overcommit: orig_count=1, DUP, commit=2'b11 -> ERR, seq_error=1 stays after dup_enable drop.
//  one_set=1 after sync pulse -> DONE, dup_done=1; one_set=0 -> ORIG, counters 0, second set completes.
//  abort in DUP with dup_count=2 -> ORIG, counts 0; abort during WAIT_RF -> pulse still at nominal cycle.
//  Async reset asserted mid-WAIT_RF, between edges -> all outputs 0 immediately, no pulse follows.

Source files
------------

// File: rtl/fv_core_dup_sequencer_if.sv
// Harness-side control and status bundle of the DUP check-set sequencer.
// The master drives the enables and commit lanes; the slave (sequencer) returns phase and counts.
interface fv_core_dup_sequencer_if #(
    parameter int unsigned MAX_COMMIT = 2,
    parameter int unsigned CNT_W      = 10
);
    logic                  dup_enable;
    logic                  cf_enable;
    logic                  one_set;
    logic                  abort;
    logic [MAX_COMMIT-1:0] commit;
    logic [MAX_COMMIT-1:0] commit_is_sync;
    logic [2:0]            dup_phase;
    logic [CNT_W-1:0]      orig_count;
    logic [CNT_W-1:0]      dup_count;
    logic                  dup_sync_ready;
    logic                  dup_done;
    logic                  seq_error;

    modport master (
        output dup_enable, cf_enable, one_set, abort, commit, commit_is_sync,
        input  dup_phase, orig_count, dup_count, dup_sync_ready, dup_done, seq_error
    );

    modport slave (
        input  dup_enable, cf_enable, one_set, abort, commit, commit_is_sync,
        output dup_phase, orig_count, dup_count, dup_sync_ready, dup_done, seq_error
    );
endinterface

// File: rtl/fv_core_dup_sequencer.sv
// Sequences one duplicate-execution check set: count originals up to the sync marker, count the
// same number of duplicates, wait out the RF write latency, then pulse dup_sync_ready.
module fv_core_dup_sequencer #(
    parameter int unsigned MAX_COMMIT  = 2,
    parameter int unsigned CNT_W       = 10,
    parameter int unsigned RF_WR_DELAY = 2,
    parameter int unsigned MAX_SEQ_LEN = 64
) (
    input logic                    clk,
    input logic                    reset,
    fv_core_dup_sequencer_if.slave bus
);
    localparam int unsigned TimerW = 4;
    localparam int unsigned SumW   = CNT_W + 1;
    localparam logic [SumW-1:0] MaxLen = SumW'(MAX_SEQ_LEN);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StOrig   = 3'd1,
        StDup    = 3'd2,
        StWaitRf = 3'd3,
        StSync   = 3'd4,
        StDone   = 3'd5,
        StErr    = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   orig_count_q, orig_count_d;
    logic [CNT_W-1:0]   dup_count_q, dup_count_d;
    logic [TimerW-1:0]  timer_q, timer_d;
    logic               dup_done_q, dup_done_d;
    logic               seq_error_q, seq_error_d;

    logic               go;
    logic               marker_found;
    logic               extra_marker;
    logic [SumW-1:0]    pre_cnt;
    logic [SumW-1:0]    post_cnt;
    logic [SumW-1:0]    orig_sum;
    logic [SumW-1:0]    dup_sum_orig;
    logic [SumW-1:0]    dup_sum_dup;

    assign go = bus.dup_enable & bus.cf_enable;

    // Lane 0 is oldest: commits before the first marker are originals, after it duplicates.
    always_comb begin
        marker_found = 1'b0;
        extra_marker = 1'b0;
        pre_cnt      = '0;
        post_cnt     = '0;
        for (int i = 0; i < int'(MAX_COMMIT); i++) begin
            if (bus.commit[i]) begin
                if (marker_found) begin
                    post_cnt = post_cnt + SumW'(1);
                    if (bus.commit_is_sync[i]) begin
                        extra_marker = 1'b1;
                    end
                end else if (bus.commit_is_sync[i]) begin
                    marker_found = 1'b1;
                end else begin
                    pre_cnt = pre_cnt + SumW'(1);
                end
            end
        end
    end

    assign orig_sum     = {1'b0, orig_count_q} + pre_cnt;
    assign dup_sum_orig = {1'b0, dup_count_q} + post_cnt;
    assign dup_sum_dup  = {1'b0, dup_count_q} + pre_cnt;

    always_comb begin
        state_d      = state_q;
        orig_count_d = orig_count_q;
        dup_count_d  = dup_count_q;
        timer_d      = timer_q;

        if (!go && (state_q inside {StOrig, StDup, StWaitRf, StSync})) begin
            state_d      = StIdle;
            orig_count_d = '0;
            dup_count_d  = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (go) begin
                        state_d      = StOrig;
                        orig_count_d = '0;
                        dup_count_d  = '0;
                    end
                end
                StOrig: begin
                    if (bus.abort) begin
                        orig_count_d = '0;
                        dup_count_d  = '0;
                    end else if (!marker_found) begin
                        if (orig_sum > MaxLen) begin
                            state_d = StErr;
                        end else begin
                            orig_count_d = orig_sum[CNT_W-1:0];
                        end
                    end else if (extra_marker || (orig_sum > MaxLen) ||
                                 (dup_sum_orig > orig_sum)) begin
                        state_d = StErr;
                    end else begin
                        orig_count_d = orig_sum[CNT_W-1:0];
                        dup_count_d  = dup_sum_orig[CNT_W-1:0];
                        state_d      = (dup_sum_orig == orig_sum) ? StWaitRf : StDup;
                    end
                end
                StDup: begin
                    if (bus.abort) begin
                        state_d      = StOrig;
                        orig_count_d = '0;
                        dup_count_d  = '0;
                    end else if (marker_found || (dup_sum_dup > {1'b0, orig_count_q})) begin
                        state_d = StErr;
                    end else begin
                        dup_count_d = dup_sum_dup[CNT_W-1:0];
                        if (dup_sum_dup == {1'b0, orig_count_q}) begin
                            state_d = StWaitRf;
                        end
                    end
                end
                StWaitRf: begin
                    if (timer_q == '0) begin
                        state_d = StSync;
                    end else begin
                        timer_d = timer_q - TimerW'(1);
                    end
                end
                StSync: begin
                    if (bus.one_set) begin
                        state_d = StDone;
                    end else begin
                        state_d      = StOrig;
                        orig_count_d = '0;
                        dup_count_d  = '0;
                    end
                end
                default: ;
            endcase
        end

        if ((state_d == StWaitRf) && (state_q != StWaitRf)) begin
            timer_d = TimerW'(RF_WR_DELAY - 1);
        end

        dup_done_d  = dup_done_q | (state_d == StDone);
        seq_error_d = seq_error_q | (state_d == StErr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            orig_count_q <= '0;
            dup_count_q  <= '0;
            timer_q      <= '0;
            dup_done_q   <= 1'b0;
            seq_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            orig_count_q <= orig_count_d;
            dup_count_q  <= dup_count_d;
            timer_q      <= timer_d;
            dup_done_q   <= dup_done_d;
            seq_error_q  <= seq_error_d;
        end
    end

    assign bus.dup_phase      = state_q;
    assign bus.orig_count     = orig_count_q;
    assign bus.dup_count      = dup_count_q;
    assign bus.dup_sync_ready = (state_q == StSync);
    assign bus.dup_done       = dup_done_q;
    assign bus.seq_error      = seq_error_q;
endmodule
